sm9_mult_driver: RTL and testbench
==================================

# sm9_mult_driver

Host-side command sequencer for the SM9 scalar multiplication core `mult`. It accepts a 256-bit scalar and base point as 32-bit word writes and holds them stable for the whole operation. It then launches the core with a one-cycle `en` pulse, waits for the core's `sign` completion flag and captures the result point into word-readable registers. Before every launch it pulses a local core reset, because the core's `sign` stays high once set.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32'd4000000: watchdog limit in WAIT cycles. Used only with `SM9_MULT_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `rst_b` in 1: reset. One clock; reset is asynchronous and active-low.
- `wr_en` in 1: word write strobe.
- `wr_addr` in 5: addresses 0–7 write `l` (0 = bits 31:0), 8–15 write `x0`, 16–23 write `y0`. Addresses 24–31 are ignored.
- `wr_data` in 32: write word.
- `start` in 1: launch request, sampled in IDLE only.
- `rd_addr` in 4: result word select. 0–7 select `x1` (0 = bits 31:0), 8–15 select `y1`.
- `rd_data` out 32: registered read data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: status of the last operation, valid from `done` until the next `start`.
- `core_rst_b` out 1: equals `rst_b & clr_n`; `clr_n` is a registered bit.
- `core_en` out 1: launch pulse to the core.
- `core_l`, `core_x0`, `core_y0` out 256: operand registers, driven directly.
- `core_x1`, `core_y1` in 256: result from the core.
- `core_sign` in 1: core completion flag, sticky.

## Operation
- Reset values: all operand and result registers 0, `rd_data`=0, `busy`=0, `done`=0, `err`=0, `core_en`=0, `clr_n`=1, state IDLE.
- Writes:
  - Accepted only in IDLE.
  - Writes while `busy` are dropped, so the operands stay stable for the core, which samples `l[count]` continuously.
- Reads:
  - `rd_data` takes the selected word on the clock edge after `rd_addr` is presented.
  - Reads are legal in any state; the result registers change only on capture.
- State machine:
  - IDLE:
    - `start`=1 and `core_l`==0 → go to ZERO. The core is never launched with a zero scalar, because the core would not terminate.
    - `start`=1 and `core_l`!=0 → go to CLR1 and set `clr_n`=0.
  - ZERO → DONE with `err`=1. Result registers are unchanged.
  - CLR1 → CLR2, with `clr_n`=0. After CLR2, `clr_n` returns to 1.
  - CLR2 → FIRE.
  - FIRE: `core_en`=1 for exactly this cycle → WAIT.
  - WAIT:
    - `core_sign`=1 → capture `core_x1`/`core_y1` into the result registers on this edge, clear `err`, go to DONE.
    - `core_sign` is ignored in CLR1, CLR2 and FIRE.
  - DONE: `done`=1 → IDLE.
- `start` asserted together with `wr_en` in IDLE: the write completes first. The zero-scalar check uses the pre-write `core_l`.
- Reset mid-operation: the FSM returns to IDLE, all registers return to reset values, and the core is reset through `core_rst_b`.

## Timing
- `start` sampled at edge T (IDLE):
  - `core_rst_b` is low for the two cycles after T.
  - `core_en` is high in cycle T+3.
  - WAIT begins at T+4.
- `core_sign` first sampled high at edge W → `done`=1 in the cycle after W, and the result is readable from that cycle.
- Zero scalar: `done`=1 in cycle T+2.
- Back-to-back operations: `start` is accepted in the IDLE cycle right after DONE. The minimum start-to-start gap is 5 cycles plus the core latency.

## Configuration
- `SM9_MULT_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches `TIMEOUT_CYCLES`-1 without `core_sign`, the FSM drives `clr_n`=0 for one cycle, sets `err`=1 and moves to DONE. Result registers are unchanged.
  - If `core_sign` and the timeout occur in the same cycle, `core_sign` wins.
- Macro undefined: no counter; WAIT lasts indefinitely. `err` is set only for a zero scalar.

## Test plan
- Normal operation:
  - Stimulus: load `l`=256'h3, `x0`=256'h1, `y0`=256'h2 and `start`. Use a stub core that returns `x1`=~x0, `y1`=~y0 and raises `sign` 100 cycles after `en`.
  - Required response:
    - `core_en` is high exactly at T+3.
    - `done` is high at T+104.
    - Words 0 and 8 read 32'hFFFFFFFE and 32'hFFFFFFFD.
    - `err`=0.
- Zero scalar:
  - Stimulus: `l`=0, then `start`.
  - Required response: `done` at T+2 with `err`=1; `core_en` and `core_rst_b` never toggle; results unchanged.
- Writes and starts while busy:
  - Stimulus: during WAIT, write `wr_addr`=0 with 32'hDEADBEEF, and pulse `start`.
  - Required response: `core_l` is unchanged and no second launch occurs.
- Two consecutive operations:
  - Stimulus: run two operations; the stub core keeps `sign` high until its own reset.
  - Required response: the second `done` waits for the second completion, because the sticky `sign` was cleared through `core_rst_b`.
- Timeout:
  - Stimulus: with `SM9_MULT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, the stub never raises `sign`.
  - Required response: `done` and `err`=1 at T+54, with `core_rst_b` low for one cycle.
- Reset mid-operation:
  - Stimulus: assert `rst_b`=0 during WAIT.
  - Required response: all outputs return to reset values immediately (asynchronously) and `core_rst_b`=0.

Source files
------------

// File: rtl/sm9_mult_driver.sv
// Command sequencer for the SM9 scalar multiplication core: loads operands by word,
// clears and launches the core, then captures its result. Optional watchdog: SM9_MULT_TIMEOUT_EN.
module sm9_mult_driver #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         start,
  input  logic [3:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         core_rst_b,
  output logic         core_en,
  output logic [255:0] core_l,
  output logic [255:0] core_x0,
  output logic [255:0] core_y0,
  input  logic [255:0] core_x1,
  input  logic [255:0] core_y1,
  input  logic         core_sign
);

  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_CLR1, S_CLR2, S_FIRE, S_WAIT, S_DONE
  } state_e;

  state_e        state_q;
  logic [255:0]  l_q, x0_q, y0_q, x1_q, y1_q;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          done_q, err_q, core_en_q, clr_n_q;
  logic [7:0]    rd_lsb, wr_lsb;

`ifdef SM9_MULT_TIMEOUT_EN
  logic [31:0]   wait_cnt_q;
`else
  logic          unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign rd_lsb = {rd_addr[2:0], 5'd0};
  assign wr_lsb = {wr_addr[2:0], 5'd0};

  always_comb begin
    rd_data_d = x1_q[rd_lsb +: 32];
    if (rd_addr[3]) rd_data_d = y1_q[rd_lsb +: 32];
  end

  // Operand writes are only honoured in IDLE, so the core sees stable inputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      l_q       <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      core_en_q <= 1'b0;
      clr_n_q   <= 1'b1;
`ifdef SM9_MULT_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      core_en_q <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= rd_data_d;
      case (state_q)
        S_IDLE: begin
          if (wr_en) begin
            case (wr_addr[4:3])
              2'd0:    l_q[wr_lsb +: 32]  <= wr_data;
              2'd1:    x0_q[wr_lsb +: 32] <= wr_data;
              2'd2:    y0_q[wr_lsb +: 32] <= wr_data;
              default: ;
            endcase
          end
          // The zero check deliberately looks at the pre-write scalar.
          if (start) begin
            err_q <= 1'b0;
            if (l_q == '0) begin
              state_q <= S_ZERO;
            end else begin
              state_q <= S_CLR1;
              clr_n_q <= 1'b0;
            end
          end
        end
        S_ZERO: begin
          err_q   <= 1'b1;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_CLR1: state_q <= S_CLR2;
        S_CLR2: begin
          clr_n_q   <= 1'b1;
          core_en_q <= 1'b1;
          state_q   <= S_FIRE;
        end
        S_FIRE: begin
          state_q <= S_WAIT;
`ifdef SM9_MULT_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (core_sign) begin
            x1_q    <= core_x1;
            y1_q    <= core_y1;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
`ifdef SM9_MULT_TIMEOUT_EN
          else if (wait_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            clr_n_q <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
`endif
        end
        S_DONE: begin
          clr_n_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data    = rd_data_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign core_rst_b = rst_b & clr_n_q;
  assign core_en    = core_en_q;
  assign core_l     = l_q;
  assign core_x0    = x0_q;
  assign core_y0    = y0_q;

endmodule

// File: tb/tb_sm9_mult_driver.sv
// Bench for sm9_mult_driver: stub core with programmable latency and sticky sign,
// operand/result model, per-cycle timing checks of each operation.
module tb_sm9_mult_driver;

  logic         clk = 1'b0;
  logic         rst_b = 1'b1;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         start = 1'b0;
  logic [3:0]   rd_addr = '0;
  logic [31:0]  rd_data;
  logic         busy, done, err, core_rst_b, core_en;
  logic [255:0] core_l, core_x0, core_y0, core_x1, core_y1;
  logic         core_sign;

  int n_vec = 0;
  int n_err = 0;
  int stub_lat = 0;
  int stub_cnt;
  logic [255:0] mdl_l, mdl_x0, mdl_y0, mdl_x1, mdl_y1;
  logic [31:0]  exp_q[$];

  sm9_mult_driver #(.TIMEOUT_CYCLES(32'd50)) dut (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .err(err), .core_rst_b(core_rst_b), .core_en(core_en), .core_l(core_l),
    .core_x0(core_x0), .core_y0(core_y0), .core_x1(core_x1), .core_y1(core_y1),
    .core_sign(core_sign)
  );

  // ---------------- clock / stub core ----------------
  always #5 clk = ~clk;

  assign core_x1 = ~core_x0;
  assign core_y1 = ~core_y0;

  always @(posedge clk or negedge core_rst_b) begin
    if (!core_rst_b) begin
      stub_cnt  <= 0;
      core_sign <= 1'b0;
    end else if (core_en) begin
      stub_cnt <= 1;
      if (stub_lat == 1) core_sign <= 1'b1;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == stub_lat - 1) core_sign <= 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mdl_l = '0; mdl_x0 = '0; mdl_y0 = '0; mdl_x1 = '0; mdl_y1 = '0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    logic [7:0] lsb;
    lsb = {a[2:0], 5'd0};
    case (a[4:3])
      2'd0: mdl_l[lsb +: 32] = d;
      2'd1: mdl_x0[lsb +: 32] = d;
      2'd2: mdl_y0[lsb +: 32] = d;
      default: ;
    endcase
  endtask

  task automatic apply_reset();
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic write_word(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic check_results();
    logic [31:0] got, exp;
    logic [7:0] lsb;
    for (int i = 0; i < 16; i++) begin
      lsb = {i[2:0], 5'd0};
      exp_q.push_back(i < 8 ? mdl_x1[lsb +: 32] : mdl_y1[lsb +: 32]);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0];
      tick();
      got = rd_data;
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rd_word[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic check_operands();
    n_vec++;
    if (core_l !== mdl_l) begin n_err++; $display("FAIL core_l got=%h exp=%h", core_l, mdl_l); end
    n_vec++;
    if (core_x0 !== mdl_x0) begin n_err++; $display("FAIL core_x0 got=%h exp=%h", core_x0, mdl_x0); end
    n_vec++;
    if (core_y0 !== mdl_y0) begin n_err++; $display("FAIL core_y0 got=%h exp=%h", core_y0, mdl_y0); end
  endtask

  // Issues start from an IDLE cycle and follows the operation cycle by cycle;
  // cycle n is the one after the n-th edge counted from the start edge.
  // Ends in the IDLE cycle that follows DONE.
  task automatic run_op(input int lat, input bit zero, input bit poke);
    int done_cyc;
    logic e_en, e_rst, e_done;
    done_cyc = zero ? 2 : 4 + lat;
    stub_lat = lat;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int cyc = 1; cyc <= done_cyc; cyc++) begin
      if (cyc > 1) tick();
      if (poke && cyc == 11) begin start = 1'b0; wr_en = 1'b0; end
      e_en   = !zero && (cyc == 3);
      e_rst  = !(!zero && (cyc == 1 || cyc == 2));
      e_done = (cyc == done_cyc);
      n_vec++;
      if (core_en !== e_en) begin n_err++; $display("FAIL core_en cyc=%0d got=%b exp=%b", cyc, core_en, e_en); end
      n_vec++;
      if (core_rst_b !== e_rst) begin n_err++; $display("FAIL core_rst_b cyc=%0d got=%b exp=%b", cyc, core_rst_b, e_rst); end
      n_vec++;
      if (done !== e_done) begin n_err++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, e_done); end
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL busy cyc=%0d got=%b exp=1", cyc, busy); end
      if (poke && cyc == 10) begin
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; start = 1'b1;
      end
    end
    n_vec++;
    if (err !== zero) begin n_err++; $display("FAIL err got=%b exp=%b", err, zero); end
    if (!zero) begin
      mdl_x1 = ~mdl_x0;
      mdl_y1 = ~mdl_y0;
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_done got=%b%b exp=00", busy, done);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({busy, done, err, core_en, core_rst_b} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_status got=%b exp=00001", {busy, done, err, core_en, core_rst_b});
    end
    n_vec++;
    if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    check_operands();
    check_results();
  endtask

  task automatic test_normal();
    write_word(5'd0, 32'h3);
    write_word(5'd8, 32'h1);
    write_word(5'd16, 32'h2);
    run_op(100, 1'b0, 1'b0);
    check_results();
    check_operands();
  endtask

  task automatic test_random_ops();
    int lat;
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < 24; a++) write_word(a[4:0], $urandom);
      write_word(5'($urandom_range(24, 31)), $urandom);
      lat = $urandom_range(1, 40);
      run_op(lat, mdl_l == '0, 1'b0);
      check_results();
      check_operands();
    end
  endtask

  task automatic test_zero();
    logic [31:0] w;
    for (int a = 0; a < 8; a++) write_word(a[4:0], 32'h0);
    run_op(5, 1'b1, 1'b0);
    check_results();
    w = $urandom | 32'h1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = w;
    model_write(5'd3, w);
    run_op(5, 1'b1, 1'b0);
    check_operands();
    run_op($urandom_range(1, 30), 1'b0, 1'b0);
    check_results();
  endtask

  task automatic test_busy();
    run_op(60, 1'b0, 1'b1);
    check_operands();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (core_en !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL relaunch i=%0d got=%b%b exp=00", i, core_en, busy);
      end
    end
    check_results();
  endtask

  task automatic test_back_to_back();
    write_word(5'd9, $urandom);
    write_word(5'd20, $urandom);
    run_op($urandom_range(1, 20), 1'b0, 1'b0);
    run_op($urandom_range(20, 45), 1'b0, 1'b0);
    check_results();
  endtask

  task automatic test_reset_mid();
    write_word(5'd12, $urandom);
    stub_lat = 200;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_b = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if ({busy, done, err, core_en, core_rst_b} !== 5'b00000) begin
      n_err++;
      $display("FAIL mid_reset_status got=%b exp=00000", {busy, done, err, core_en, core_rst_b});
    end
    n_vec++;
    if (rd_data !== 32'h0) begin n_err++; $display("FAIL mid_reset_rd_data got=%h exp=0", rd_data); end
    check_operands();
    tick();
    rst_b = 1'b1;
    tick();
    n_vec++;
    if (core_rst_b !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset got=%b%b exp=10", core_rst_b, busy);
    end
    check_results();
  endtask

`ifdef SM9_MULT_TIMEOUT_EN
  task automatic test_timeout();
    logic e_rst;
    write_word(5'd0, 32'h5);
    stub_lat = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 54; cyc++) begin
      if (cyc > 1) tick();
      e_rst = !(cyc == 1 || cyc == 2 || cyc == 54);
      n_vec++;
      if (done !== (cyc == 54)) begin n_err++; $display("FAIL tmo_done cyc=%0d got=%b", cyc, done); end
      n_vec++;
      if (core_rst_b !== e_rst) begin n_err++; $display("FAIL tmo_core_rst_b cyc=%0d got=%b exp=%b", cyc, core_rst_b, e_rst); end
    end
    n_vec++;
    if (err !== 1'b1) begin n_err++; $display("FAIL tmo_err got=%b exp=1", err); end
    tick();
    check_results();
  endtask
`endif

  // ---------------- main sequence / report ----------------
  initial begin
    #2;
    test_reset();
    test_normal();
    test_random_ops();
    test_zero();
    test_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef SM9_MULT_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
